// File: rtl/unary_stream_dec_if.sv
// Result-side handshake of the unary stream decoder: window count, valid/ready
// and the sticky overflow flag that the producer raises when a result is lost.
interface unary_stream_dec_if #(
    parameter int DEP = 5
);
    logic           out_vld;
    logic           out_rdy;
    logic [DEP:0]   cnt_out;
    logic           ovf;

    modport master (
        output out_vld,
        output cnt_out,
        output ovf,
        input  out_rdy
    );

    modport slave (
        input  out_vld,
        input  cnt_out,
        input  ovf,
        output out_rdy
    );
endinterface

// File: rtl/unary_stream_dec.sv
// Counts the 1s of a qualified unary bitstream over windows of 2^DEP cycles and
// hands each count out through a single result register with valid/ready.
module unary_stream_dec #(
    parameter int DEP = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in,
    input  logic                 en,
    input  logic                 clr,
    unary_stream_dec_if.master   res
);
    localparam logic [DEP-1:0] WIN_LAST = '1;
    localparam logic [DEP-1:0] WIN_ONE  = {{(DEP-1){1'b0}}, 1'b1};

    logic [DEP:0]   acc;
    logic [DEP-1:0] win;

    logic           qual;
    logic           done;
    logic           slot_free;
    logic           xfer;
    logic [DEP:0]   acc_next;

    // clr wins over en, so a clearing cycle can never complete a window
    assign qual      = en & ~clr;
    assign done      = qual & (win == WIN_LAST);
    assign acc_next  = acc + {{DEP{1'b0}}, in};
    assign xfer      = res.out_vld & res.out_rdy;
    assign slot_free = ~res.out_vld | res.out_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            win         <= '0;
            res.out_vld <= 1'b0;
            res.cnt_out <= '0;
            res.ovf     <= 1'b0;
        end else begin
            if (clr) begin
                acc     <= '0;
                win     <= '0;
                res.ovf <= 1'b0;
            end else if (qual) begin
                win <= win + WIN_ONE;
                acc <= done ? '0 : acc_next;
            end

            // A completion that finds the slot full and not draining is dropped
            if (done && !slot_free) begin
                res.ovf <= 1'b1;
            end

            if (done && slot_free) begin
                res.cnt_out <= acc_next;
                res.out_vld <= 1'b1;
            end else if (xfer) begin
                res.out_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_unary_stream_dec.sv
// Directed bench for unary_stream_dec: a vector table of whole-window runs plus
// hand-written sequences for stalls, overflow, same-cycle drain and mid-window resets.
module tb_unary_stream_dec;
    localparam int DEP = 5;

    typedef struct {
        int mode;
        int en_mode;
        int exp_cnt;
        int exp_cycles;
        string name;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in = 1'b0;
    logic en = 1'b0;
    logic clr = 1'b0;

    int total = 0;
    int bad = 0;

    unary_stream_dec_if #(.DEP(DEP)) res_if ();

    unary_stream_dec #(.DEP(DEP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .en    (en),
        .clr   (clr),
        .res   (res_if.master)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge
    task automatic applyStimulus(input logic b, input logic e, input logic c, input logic r);
        in = b;
        en = e;
        clr = c;
        res_if.out_rdy = r;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Bit pattern indexed by qualified-cycle number q
    function automatic logic patternBit(input int mode, input int q);
        case (mode)
            0: return 1'b1;
            1: return (q % 2 == 0);
            2: return 1'b0;
            3: return (q < 5);
            4: return (q % 4 == 0);
            default: return 1'b0;
        endcase
    endfunction

    task automatic runToValid(input int mode, input int en_mode, output int cycles, output int cnt);
        int q;
        logic e;
        q = 0;
        cycles = 0;
        cnt = -1;
        for (int c = 0; c < 200; c++) begin
            e = (en_mode == 0) ? 1'b1 : logic'(c % 2 == 1);
            applyStimulus(patternBit(mode, q), e, 1'b0, 1'b1);
            if (e) q++;
            if (res_if.out_vld) begin
                cycles = c + 1;
                cnt = int'(res_if.cnt_out);
                break;
            end
        end
    endtask

    vec_t vecs[7];

    initial begin
        int cycles;
        int cnt;
        int vld_count;
        int wrong_pos;

        vecs[0] = '{0, 0, 32, 32, "all_ones"};
        vecs[1] = '{1, 0, 16, 32, "alternating"};
        vecs[2] = '{2, 0, 0, 32, "all_zeros"};
        vecs[3] = '{3, 0, 5, 32, "five_ones"};
        vecs[4] = '{4, 0, 8, 32, "every_fourth"};
        vecs[5] = '{0, 1, 32, 64, "ones_en_toggle"};
        vecs[6] = '{1, 1, 16, 64, "alt_en_toggle"};

        res_if.out_rdy = 1'b1;
        #12;
        checkOutput("reset_vld", int'(res_if.out_vld), 0);
        checkOutput("reset_cnt", int'(res_if.cnt_out), 0);
        checkOutput("reset_ovf", int'(res_if.ovf), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
            checkOutput({vecs[i].name, "_pre_vld"}, int'(res_if.out_vld), 0);
            runToValid(vecs[i].mode, vecs[i].en_mode, cycles, cnt);
            checkOutput({vecs[i].name, "_cnt"}, cnt, vecs[i].exp_cnt);
            checkOutput({vecs[i].name, "_cycles"}, cycles, vecs[i].exp_cycles);
            checkOutput({vecs[i].name, "_ovf"}, int'(res_if.ovf), 0);
        end

        // Full-rate streaming: a result exactly every 32 cycles, no bubbles
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        vld_count = 0;
        wrong_pos = 0;
        for (int c = 0; c < 96; c++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
            if (res_if.out_vld) begin
                vld_count++;
                if (c % 32 != 31 || res_if.cnt_out != 6'd32) wrong_pos++;
            end else if (c % 32 == 31) begin
                wrong_pos++;
            end
        end
        checkOutput("stream_vld_count", vld_count, 3);
        checkOutput("stream_wrong_pos", wrong_pos, 0);
        checkOutput("stream_ovf", int'(res_if.ovf), 0);

        // Stalled consumer: second completion is dropped and ovf sticks
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        for (int c = 0; c < 32; c++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("stall_first_vld", int'(res_if.out_vld), 1);
        checkOutput("stall_first_cnt", int'(res_if.cnt_out), 32);
        checkOutput("stall_first_ovf", int'(res_if.ovf), 0);
        for (int c = 32; c < 63; c++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("stall_pre_drop_ovf", int'(res_if.ovf), 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("stall_drop_ovf", int'(res_if.ovf), 1);
        checkOutput("stall_drop_cnt", int'(res_if.cnt_out), 32);
        for (int c = 64; c < 70; c++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("stall_xfer_vld", int'(res_if.out_vld), 0);
        checkOutput("stall_xfer_cnt", int'(res_if.cnt_out), 32);
        for (int c = 0; c < 5; c++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("stall_ovf_sticky", int'(res_if.ovf), 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("stall_clr_ovf", int'(res_if.ovf), 0);

        // Drain and completion on the same edge keep out_vld high
        for (int c = 0; c < 32; c++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("same_setup_cnt", int'(res_if.cnt_out), 32);
        for (int c = 0; c < 31; c++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("same_hold_vld", int'(res_if.out_vld), 1);
        checkOutput("same_hold_cnt", int'(res_if.cnt_out), 32);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("same_vld", int'(res_if.out_vld), 1);
        checkOutput("same_cnt", int'(res_if.cnt_out), 0);
        checkOutput("same_ovf", int'(res_if.ovf), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("same_drain_vld", int'(res_if.out_vld), 0);

        // Mid-window asynchronous reset with a pending result
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 42; c++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("rst_pre_vld", int'(res_if.out_vld), 1);
        en = 1'b0;
        rst_n = 1'b0;
        #2;
        checkOutput("rst_mid_vld", int'(res_if.out_vld), 0);
        checkOutput("rst_mid_cnt", int'(res_if.cnt_out), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        runToValid(0, 0, cycles, cnt);
        checkOutput("rst_restart_cycles", cycles, 32);
        checkOutput("rst_restart_cnt", cnt, 32);

        // Mid-window clr leaves the pending result alone
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        for (int c = 0; c < 32; c++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("clr_mid_vld", int'(res_if.out_vld), 1);
        checkOutput("clr_mid_cnt", int'(res_if.cnt_out), 32);
        runToValid(0, 0, cycles, cnt);
        checkOutput("clr_restart_cycles", cycles, 32);
        checkOutput("clr_restart_cnt", cnt, 32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/unary_stream_dec.md
# unary_stream_dec

Unary bitstream decoder: counts the 1s in a unipolar stochastic bitstream over a fixed window of 2^DEP qualified cycles and presents the count as a binary result. It sits at the output of unary compute kernels such as the square-root unit and converts their bitstream back to binary for checking or downstream binary logic. Each result is held in an output register behind a valid/ready handshake. A sticky flag records any result that is lost because the consumer stalled.

## Interface
- DEP, 5, log2 of the window length; window = 2^DEP qualified cycles, result width DEP+1

- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous reset, active low
- in  input  1  unary bitstream bit
- en  input  1  qualifies `in`; cycles with en=0 are ignored entirely
- clr  input  1  synchronous clear of the in-progress window and the ovf flag
- out_rdy  input  1  consumer ready for the result
- out_vld  output  1  result register holds an unconsumed result
- cnt_out  output  DEP+1  window count of 1s, range 0..2^DEP
- ovf  output  1  sticky; a completed window result was dropped

## Operation
- Internal state: `acc` [DEP:0] ones accumulator; `win` [DEP-1:0] qualified-cycle counter.
- Qualified cycle (en=1, clr=0):
  - `acc` <= `acc` + `in`.
  - `win` <= `win` + 1, wrapping from 2^DEP-1 to 0.
- Window completion is a qualified cycle with `win` == 2^DEP-1. On completion:
  - final = `acc` + `in`, range 0..2^DEP.
  - `acc` <= 0.
  - `win` wraps to 0.
- Loading the result on completion:
  - Slot free (out_vld=0) or draining this cycle (out_vld & out_rdy): cnt_out <= final, out_vld <= 1.
  - Slot occupied and not draining: final is discarded, ovf <= 1, cnt_out unchanged.
- Handshake:
  - Transfer occurs on any edge with out_vld & out_rdy.
  - After a transfer with no simultaneous load: out_vld <= 0; cnt_out keeps its last value.
  - cnt_out is stable while out_vld=1 and out_rdy=0.
- clr=1:
  - `acc` <= 0, `win` <= 0, ovf <= 0.
  - clr has priority over en, so `in` is ignored that cycle and no completion is possible.
  - cnt_out, out_vld and the handshake are unaffected; a transfer in the same cycle still completes.
- en=0, clr=0: `acc` and `win` hold.
- Arithmetic: `acc` never exceeds 2^DEP, so no saturation logic is needed. Width DEP+1 is exact.

## Timing
- Reset (rst_n=0, asynchronous): `acc`=0, `win`=0, out_vld=0, cnt_out=0, ovf=0.
- Reset mid-window discards the partial window. Counting restarts at the first qualified cycle after release.
- Latency: out_vld and cnt_out update on the same edge that samples the final qualified bit, and are visible in the following cycle.
- Throughput: one result per 2^DEP qualified cycles. There is no bubble between windows, and completion plus drain in the same cycle sustains full rate.
- ovf asserts on the edge of the dropped completion and stays high until clr or reset.
- out_rdy, en, in and clr have no combinational path to any output.

## Test plan
- DEP=5, en=1, in=1 constant, out_rdy=1:
  - out_vld first rises after edge 32 with cnt_out=32.
  - Thereafter a result every 32 cycles; ovf=0.
- in alternating 1,0 with en=1, out_rdy=1 → every result is cnt_out=16.
- in=1 constant, en toggling 1,0 → the first result arrives after 64 cycles with cnt_out=32; en=0 cycles contribute nothing.
- out_rdy=0 for 70 cycles, in=1:
  - First window loads cnt_out=32, out_vld=1.
  - Second completion at cycle 64 is dropped and ovf=1.
  - When out_rdy rises, cnt_out=32 transfers once and out_vld falls.
  - ovf stays high until a clr pulse clears it.
- Simultaneous drain and complete:
  - Setup: out_vld=1 holding 32; in pattern switched to all zeros for the next window.
  - Drive out_rdy=1 exactly on the completion cycle.
  - Required: out_vld stays 1, cnt_out becomes 0, ovf=0.
- Mid-window events:
  - rst_n low for 1 cycle after 10 ones → out_vld=0, cnt_out=0; the next window (in=1) yields 32 after a full 32 qualified cycles.
  - clr after 10 ones → same restart behaviour, and out_vld is not disturbed.
